// File: rtl/echo_mix.sv
// Echo/comb mixing stage: wet = sat(dry + delayed * gain / 2^GAIN_W).
// The multiply is shift-add over GAIN_W clocks, one gain bit per clock, LSB first.
module echo_mix #(
    parameter int WIDTH  = 12,
    parameter int GAIN_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_valid,
    input  logic signed [WIDTH-1:0] dry_in,
    input  logic signed [WIDTH-1:0] delayed_in,
    input  logic [GAIN_W-1:0]       gain,
    output logic signed [WIDTH-1:0] wet_out,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int ACC_W = WIDTH + GAIN_W + 1;
    localparam int CNT_W = (GAIN_W > 1) ? $clog2(GAIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(GAIN_W - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] SUM  = 2'd2;

    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]              state_q, state_d;
    logic signed [WIDTH-1:0] dry_q, dry_d;
    logic signed [ACC_W-1:0] mcand_q, mcand_d;
    logic [GAIN_W-1:0]       gain_q, gain_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [WIDTH-1:0] wet_q, wet_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overrun_q, overrun_d;

    logic signed [WIDTH:0]   scaled;
    logic signed [WIDTH:0]   sum_ext;
    logic signed [WIDTH-1:0] sum_sat;

    // acc >>> GAIN_W fits in WIDTH bits, so WIDTH+1 bits of the shifted value suffice.
    always_comb begin
        scaled  = $signed(acc_q[GAIN_W +: WIDTH+1]);
        sum_ext = $signed({dry_q[WIDTH-1], dry_q}) + scaled;
        if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) begin
            sum_sat = sum_ext[WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            sum_sat = sum_ext[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        dry_d       = dry_q;
        mcand_d     = mcand_q;
        gain_d      = gain_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        wet_d       = wet_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q | (sample_valid && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    dry_d   = dry_in;
                    mcand_d = {{(GAIN_W+1){delayed_in[WIDTH-1]}}, delayed_in};
                    gain_d  = gain;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                // Multiplicand shifts left as gain shifts right, so bit 0 is always examined.
                if (gain_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q <<< 1;
                gain_d  = gain_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = SUM;
                end
            end
            SUM: begin
                wet_d       = sum_sat;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dry_q       <= '0;
            mcand_q     <= '0;
            gain_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            wet_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dry_q       <= dry_d;
            mcand_q     <= mcand_d;
            gain_q      <= gain_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            wet_q       <= wet_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign wet_out   = wet_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_echo_mix.sv
// Directed bench for echo_mix: scoreboard of expected wet samples, popped on each out_valid.
module tb_echo_mix;

    localparam int WIDTH  = 12;
    localparam int GAIN_W = 8;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    sample_valid;
    logic signed [WIDTH-1:0] dry_in;
    logic signed [WIDTH-1:0] delayed_in;
    logic [GAIN_W-1:0]       gain;
    logic signed [WIDTH-1:0] wet_out;
    logic                    out_valid;
    logic                    busy;
    logic                    overrun;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    integer exp_q[$];

    echo_mix #(
        .WIDTH  (WIDTH),
        .GAIN_W (GAIN_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .dry_in       (dry_in),
        .delayed_in   (delayed_in),
        .gain         (gain),
        .wet_out      (wet_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input integer obs, input integer exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic integer model(input integer d, input integer dl, input integer g);
        integer s;
        s = d + ((dl * g) >>> GAIN_W);
        if (s > 2047) s = 2047;
        if (s < -2048) s = -2048;
        return s;
    endfunction

    // Called at a negedge; the strobe is accepted at the following posedge.
    task automatic strobe(input integer d, input integer dl, input integer g);
        dry_in       = d[WIDTH-1:0];
        delayed_in   = dl[WIDTH-1:0];
        gain         = g[GAIN_W-1:0];
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        dry_in       = WIDTH'($urandom);
        delayed_in   = WIDTH'($urandom);
        gain         = GAIN_W'($urandom);
    endtask

    task automatic wait_result(input string tag, input bit check_drop);
        int n;
        int busy_cnt;
        n = 0;
        busy_cnt = 0;
        while (n < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (out_valid === 1'b1) break;
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, GAIN_W + 1);
        check({tag, "_busy_cycles"}, busy_cnt, GAIN_W + 1);
        if (check_drop) begin
            @(negedge clk);
            check({tag, "_valid_one_cycle"}, out_valid, 0);
        end
    endtask

    // Scoreboard consumer
    initial begin
        integer e;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1 && out_valid === 1'b1) begin
                pulses++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_out_valid observed=%0d expected=none", wet_out);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wet_out", wet_out, e);
                end
            end
        end
    end

    initial begin
        int base;
        integer d, dl, g;

        reset        = 1'b1;
        sample_valid = 1'b0;
        dry_in       = '0;
        delayed_in   = '0;
        gain         = '0;
        repeat (3) @(negedge clk);
        check("rst_wet_out", wet_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic mix
        exp_q.push_back(356);
        strobe(100, 512, 128);
        wait_result("basic", 1'b1);
        check("basic_hold", wet_out, 356);

        // Saturation both ways
        exp_q.push_back(2047);
        strobe(2000, 2047, 255);
        wait_result("sat_pos", 1'b1);
        exp_q.push_back(-2048);
        strobe(-2000, -2048, 255);
        wait_result("sat_neg", 1'b1);

        // Floor rounding and zero gain
        exp_q.push_back(-1);
        strobe(0, -1, 1);
        wait_result("floor", 1'b1);
        exp_q.push_back(-300);
        strobe(-300, 900, 0);
        wait_result("gain0", 1'b1);
        check("no_overrun_yet", overrun, 0);

        // Overrun: second strobe arrives 3 clocks after acceptance
        base = pulses;
        exp_q.push_back(74);
        strobe(10, 256, 64);
        repeat (2) @(negedge clk);
        strobe(999, 100, 200);
        check("overrun_set", overrun, 1);
        repeat (12) @(negedge clk);
        check("overrun_pulses", pulses - base, 1);
        check("overrun_wet", wet_out, 74);
        check("overrun_sticky", overrun, 1);

        // Reset in the middle of MUL discards the computation
        strobe(1000, 1000, 200);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        base = pulses;
        check("midrst_wet", wet_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overrun", overrun, 0);
        repeat (15) @(negedge clk);
        check("midrst_no_pulse", pulses - base, 0);
        exp_q.push_back(731);
        strobe(-50, 1000, 200);
        wait_result("after_rst", 1'b1);

        // Back-to-back: second strobe lands in the out_valid cycle
        base = pulses;
        exp_q.push_back(128);
        strobe(0, 256, 128);
        wait_result("b2b_a", 1'b0);
        exp_q.push_back(-123);
        strobe(5, -256, 128);
        wait_result("b2b_b", 1'b1);
        check("b2b_pulses", pulses - base, 2);
        check("b2b_overrun", overrun, 0);

        // A few random samples against the reference formula
        for (int i = 0; i < 4; i++) begin
            d  = int'($urandom_range(4095)) - 2048;
            dl = int'($urandom_range(4095)) - 2048;
            g  = int'($urandom_range(255));
            exp_q.push_back(model(d, dl, g));
            strobe(d, dl, g);
            wait_result("random", 1'b1);
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
